// File: rtl/booth_pp_gen_pipe.sv
// booth_pp_gen_pipe: radix-8 Booth partial-product generator emitting one weighted row per handshake.
// Define R8_APPROX_3A_EN to build 3A with its APX_K low bits formed carry-free.
module booth_pp_gen_pipe #(
    parameter int W = 16,
    parameter int APX_K = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_pp,
    output logic [((W+2)/3 > 1 ? $clog2((W+2)/3) : 1)-1:0] out_row,
    output logic            out_last
);
    localparam int ROWS = (W + 2) / 3;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BX = 3 * ROWS + 1;
    localparam int PW = 2 * W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q;
    logic          take, adv, done;
    logic [RW-1:0] row_nx;

    // 3A is split at APX_K: the upper halves are always added exactly,
    // the low halves are either added (exact) or OR-ed (carry-free approximation).
    function automatic logic [PW-1:0] row_pp(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [RW-1:0] idx);
        logic signed [PW-1:0] ax, a2, hi, a3;
        logic [PW-1:0]        mask, m, p;
        logic signed [BX-1:0] bs;
        logic [3:0]           dg;
        logic [2:0]           s, mag;
        ax = PW'($signed(a));
        a2 = ax <<< 1;
        mask = PW'((64'd1 << APX_K) - 64'd1);
        hi = ((a2 >>> APX_K) + (ax >>> APX_K)) <<< APX_K;
`ifdef R8_APPROX_3A_EN
        a3 = hi | ((a2 | ax) & mask);
`else
        a3 = hi + (a2 & mask) + (ax & mask);
`endif
        bs = BX'($signed(b));
        dg = 4'({bs[BX-2:0], 1'b0} >> (3 * int'(idx)));
        s = {1'b0, dg[2:1]} + {2'b00, dg[0]};
        mag = dg[3] ? 3'd4 - s : s;
        m = mag == 3'd1 ? ax : mag == 3'd2 ? a2 : mag == 3'd3 ? a3 : mag == 3'd4 ? (ax <<< 2) : '0;
        p = dg[3] ? ~m + 1'b1 : m;
        return p << (3 * int'(idx));
    endfunction

    assign row_nx = out_row + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        in_ready = state == IDLE || (state == RUN && out_last && out_ready);
        out_valid = state == RUN;
        take = in_valid && in_ready;
        adv = out_valid && out_ready && !out_last;
        done = out_valid && out_ready && out_last;
        state_nx = take ? RUN : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            out_pp   <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
        end else if (take) begin
            a_q      <= in_a;
            b_q      <= in_b;
            out_pp   <= row_pp(in_a, in_b, '0);
            out_row  <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            out_pp   <= row_pp(a_q, b_q, row_nx);
            out_row  <= row_nx;
            out_last <= row_nx == RW'(ROWS - 1);
        end else if (done) begin
            out_pp   <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_booth_pp_gen_pipe.sv
// tb_booth_pp_gen_pipe: scoreboard bench for booth_pp_gen_pipe (W=16, six rows per operation).
module tb_booth_pp_gen_pipe;
    localparam int W = 16;

    typedef struct packed {
        logic             exact;
        logic [5:0][31:0] rows;
        logic [31:0]      prod;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_pp;
    logic [2:0]  out_row;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cnt = 0;
    logic [31:0] sum = '0;
    logic        b2b = 1'b0;
    logic [15:0] ra, rb;
    int          pa, pb;

    booth_pp_gen_pipe #(.W(W), .APX_K(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_pp(out_pp), .out_row(out_row), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic ex, input logic [5:0][31:0] r, input logic [31:0] p);
        exp_t e;
        e.exact = ex;
        e.rows = r;
        e.prod = p;
        return e;
    endfunction

    // Monitor: pops one scoreboard entry per operation, checking each row as it is accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
            sum = '0;
            b2b = 1'b0;
        end else begin
            if (b2b) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_row0", 32'(out_row), 32'd0);
            end
            b2b = out_valid && out_ready && out_last && in_valid;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got row %0d pp %h, required no output", out_row, out_pp);
                end else begin
                    chk("row_idx", 32'(out_row), 32'(cnt));
                    chk("row_last", 32'(out_last), 32'(cnt == 5));
                    if (q[0].exact && cnt < 6)
                        chk("row_pp", out_pp, q[0].rows[cnt]);
                    sum += out_pp;
                    if (out_last) begin
                        chk("row_sum", sum, q[0].prod);
                        void'(q.pop_front());
                        cnt = 0;
                        sum = '0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int   n;
        logic acc;
        n = 0;
        q.push_back(e);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no acceptance within %0d cycles, required acceptance", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending operations, required 0", q.size());
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pp", out_pp, 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'd3, 16'd5, mk(1'b1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h18, 32'hFFFFFFF7}, 32'd15));
        drain();
        send(16'hFFFF, 16'h7FFF, mk(1'b1, {32'hFFFF8000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1}, 32'hFFFF8001));
        drain();
`ifdef R8_APPROX_3A_EN
        send(16'd7, 16'd3, mk(1'b1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd15}, 32'd15));
`else
        send(16'd7, 16'd3, mk(1'b1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd21}, 32'd21));
`endif
        drain();
        send(16'hFFFD, 16'hFFFE, mk(1'b0, '0, 32'd6));
        drain();

        // Backpressure at row 2 while a competing operand pair is offered.
        send(16'd5, 16'h0060, mk(1'b1, {32'h0, 32'h0, 32'h0, 32'h280, 32'hFFFFFF60, 32'h0}, 32'd480));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_row_start", 32'(out_row), 32'd2);
        in_a = 16'd7;
        in_b = 16'd7;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_pp", out_pp, 32'h280);
            chk("bp_row", 32'(out_row), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ignored", 32'(out_valid), 32'd0);

`ifndef R8_APPROX_3A_EN
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            pa = $signed(ra);
            pb = $signed(rb);
            send(ra, rb, mk(1'b0, '0, 32'(pa * pb)));
        end
        drain();
`endif

        // Reset pulse at row 3 discards the operation in flight.
        send(16'd3, 16'd5, mk(1'b1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h18, 32'hFFFFFFF7}, 32'd15));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_row", 32'(out_row), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pp", out_pp, 32'd0);
        chk("mid_rst_row", 32'(out_row), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        send(16'd5, 16'h0060, mk(1'b1, {32'h0, 32'h0, 32'h0, 32'h280, 32'hFFFFFF60, 32'h0}, 32'd480));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
